// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the execute-stage request/response handshake and the word-wide
// data-memory port of mem_access_unit. The slave modport is the unit itself.
// The master modport is its environment: the requester plus the memory,
// which returns mem_rdata.
interface mem_access_unit_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
);
    // Request channel, accepted only while req_ready is high.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [31:0]           req_addr;
    logic [WIDTH-1:0]      req_wdata;

    // Completion pulse. There is no backpressure.
    logic                  resp_valid;
    logic [WIDTH-1:0]      resp_rdata;
    logic                  resp_fault;

    // Word-wide memory port. Read data arrives one cycle after the read.
    logic                  mem_mode;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  mem_mode, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        output mem_mode, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer in front of the word-wide data memory.
// - Byte and halfword loads select a little-endian lane, then sign- or
//   zero-extend it.
// - Sub-word stores become a read-modify-write on the memory port.
// - Misaligned or illegal-size requests fault without a memory cycle.
module mem_access_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic                  r_write;
    logic [WIDTH-1:0]      r_wdata;
    logic [WIDTH-1:0]      r_mem_wdata;
    logic [WIDTH-1:0]      r_resp_rdata;
    logic                  r_resp_fault;

    logic                  w_fault;
    logic [4:0]            w_shift;
    logic [WIDTH-1:0]      w_lane_data;
    logic [WIDTH-1:0]      w_load_data;
    logic [WIDTH-1:0]      w_mask;
    logic [WIDTH-1:0]      w_merged;
    logic                  w_unused_addr;

    // Address bits above the memory range wrap. They are gathered here so
    // that dropping them is explicit.
    assign w_unused_addr = &{1'b0, bus.req_addr[31:ADDR_WIDTH+2]};

    // Alignment check on the live request. It is only used at accept.
    assign w_fault = (bus.req_size == 2'b11)
                   || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                   || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

    // Lane position in bits. Words are aligned, so their shift is 0.
    assign w_shift     = {r_lane, 3'b000};
    assign w_lane_data = bus.mem_rdata >> w_shift;

    // Sub-word store merge: replace the selected lane, keep the other bytes.
    assign w_mask   = ((r_size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
    assign w_merged = (bus.mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);

    // Load result: the extracted lane, extended according to the signed flag.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_load_data = w_lane_data;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{r_signed & w_lane_data[7]}},  w_lane_data[7:0]};
            SZ_HALF: w_load_data = {{16{r_signed & w_lane_data[15]}}, w_lane_data[15:0]};
            default: w_load_data = w_lane_data;
        endcase
    end

    // Sequencer state, latched request and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_lane       <= 2'b00;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_mem_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments. Every register updates from
            // the pre-edge values, whatever the statement order.
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr   <= bus.req_addr[ADDR_WIDTH+1:2];
                        r_lane   <= bus.req_addr[1:0];
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_write  <= bus.req_write;
                        r_wdata  <= bus.req_wdata;
                        if (w_fault) begin
                            r_resp_rdata <= '0;
                            r_resp_fault <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                            r_mem_wdata <= bus.req_wdata;
                            r_state     <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (r_write) begin
                        r_mem_wdata <= w_merged;
                        r_state     <= S_WR;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_fault <= 1'b0;
                        r_state      <= S_RESP;
                    end
                end
                S_WR: begin
                    r_resp_rdata <= '0;
                    r_resp_fault <= 1'b0;
                    r_state      <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the strobes are decoded from state rather than registered.
    // Asserting reset therefore drops mem_mode at once, and a pending
    // read-modify-write never reaches the memory.
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.mem_mode   = (r_state == S_WR);
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_fault = r_resp_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Scoreboard bench for mem_access_unit.
// - The driver issues requests and pushes the expected response: data,
//   fault flag, the edge of the response pulse, and the memory write count.
// - The expected values come from a byte-addressed reference memory.
// - A monitor pops and compares on every resp_valid.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          edge_no;
        int          writes;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   writes_seen = 0;
    exp_t sb[$];

    logic [31:0] mem_words [1024];
    logic [7:0]  ref_mem   [4096];

    always #5 clk = ~clk;

    // Count rising edges. Responses are timed against this counter.
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if #(.WIDTH(32), .ADDR_WIDTH(10)) bus_if ();

    mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // Word memory: write on mem_mode; read data appears one cycle later.
    always @(posedge clk) begin
        if (bus_if.mem_mode) mem_words[bus_if.mem_addr] <= bus_if.mem_wdata;
        bus_if.mem_rdata <= mem_words[bus_if.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model, written in terms of bytes:
    // - faults: illegal size, or the address is not a multiple of the size
    // - stores: write the low bytes
    // - loads: gather bytes little-endian, then extend
    function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output exp_t e, output int lat);
        int          nbytes;
        int          a;
        logic [31:0] v;
        e.rdata  = 32'h0;
        e.fault  = 1'b0;
        e.writes = 0;
        a        = int'(addr & 32'h0000_0FFF);
        nbytes   = 1 << sz;
        if (sz == 2'b11 || (a % nbytes) != 0) begin
            e.fault = 1'b1;
            lat     = 1;
        end else if (w) begin
            for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
            e.writes = 1;
            lat      = (nbytes == 4) ? 2 : 4;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
            e.rdata = v;
            lat     = 3;
        end
    endfunction

    // Monitor: every response must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   w;
        if (!reset) begin
            w = writes_seen + (bus_if.mem_mode ? 1 : 0);
            if (bus_if.resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", bus_if.resp_rdata, e.rdata);
                    check("resp_fault", 32'(bus_if.resp_fault), 32'(e.fault));
                    check("resp_edge", cyc + 1, e.edge_no);
                    check("write_cycles", w, e.writes);
                end
                writes_seen <= 0;
            end else begin
                writes_seen <= w;
            end
        end
    end

    // Issue one request. The caller is at a negedge; the task returns at one.
    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        exp_t e;
        int   lat;
        int   n = 0;
        bus_if.req_write  = w;
        bus_if.req_size   = sz;
        bus_if.req_signed = sg;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        bus_if.req_valid  = 1'b1;
        while (!bus_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus_if.req_valid = 1'b0;
            return;
        end
        model(w, sz, sg, a, wd, e, lat);
        e.edge_no = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        check("ready_low_busy", 32'(bus_if.req_ready), 32'd0);
        if (!hold) begin
            // Scramble the request fields after accept; they must be ignored.
            bus_if.req_valid = 1'b0;
            bus_if.req_addr  = $urandom;
            bus_if.req_wdata = $urandom;
            bus_if.req_size  = 2'($urandom_range(0, 3));
            bus_if.req_write = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin : stim
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        int          n;

        for (int i = 0; i < 1024; i++) mem_words[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
        reset = 1'b1;
        bus_if.req_valid  = 1'b0;
        bus_if.req_write  = 1'b0;
        bus_if.req_size   = 2'b00;
        bus_if.req_signed = 1'b0;
        bus_if.req_addr   = 32'h0;
        bus_if.req_wdata  = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(bus_if.resp_fault), 32'd0);
        check("rst_mem_mode", 32'(bus_if.mem_mode), 32'd0);
        check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        check("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);

        // Word store then word load; byte store RMW then word load.
        drive(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        drive(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_0011, 1'b0);
        drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

        // Sign and zero extension of byte and halfword lanes.
        drive(1'b1, 2'b10, 1'b0, 32'h50, 32'h80F0_7F81, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 32'h50, 32'h0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 1'b0);
        drive(1'b0, 2'b01, 1'b1, 32'h52, 32'h0, 1'b0);
        drive(1'b0, 2'b01, 1'b0, 32'h52, 32'h0, 1'b0);

        // Faults: misaligned half, misaligned word, illegal size.
        drive(1'b0, 2'b01, 1'b1, 32'h43, 32'h0, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 32'h42, 32'h1234_5678, 1'b0);
        drive(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0);
        drain();

        // Half store to 0x46 abandoned by reset while in RD_WAIT.
        bus_if.req_write  = 1'b1;
        bus_if.req_size   = 2'b01;
        bus_if.req_signed = 1'b0;
        bus_if.req_addr   = 32'h46;
        bus_if.req_wdata  = 32'h0000_ABCD;
        bus_if.req_valid  = 1'b1;
        n = 0;
        while (!bus_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rmw_accept_ready", 32'(bus_if.req_ready), 32'd1);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_mode", 32'(bus_if.mem_mode), 32'd0);
        check("arst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("arst_resp_rdata", bus_if.resp_rdata, 32'd0);
        check("arst_resp_fault", 32'(bus_if.resp_fault), 32'd0);
        check("arst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        check("arst_mem_wdata", bus_if.mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("arst_req_ready", 32'(bus_if.req_ready), 32'd1);
        repeat (6) @(negedge clk);
        // The abandoned store must not have changed memory.
        drive(1'b0, 2'b01, 1'b0, 32'h46, 32'h0, 1'b0);

        // Four loads with req_valid held high throughout.
        drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
        drive(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b1);
        drive(1'b0, 2'b00, 1'b1, 32'h51, 32'h0, 1'b1);
        drive(1'b0, 2'b01, 1'b1, 32'h52, 32'h0, 1'b0);
        drain();

        // Random mix: a small address window, high address bits that wrap,
        // occasional illegal sizes and misalignment.
        for (int k = 0; k < 150; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            a  = 32'h100 + 32'($urandom_range(0, 31));
            if (sz != 2'b11 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
            drive(w, sz, sg, a, $urandom, 1'($urandom_range(0, 1)));
        end
        bus_if.req_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer placed directly upstream of the word-wide data memory (`mem`). It accepts byte/halfword/word load and store requests from the execute stage, performs little-endian lane selection with sign or zero extension, and turns sub-word stores into read-modify-write sequences on the memory port. Misaligned or illegal-size requests fault without touching memory.

## Interface
- `WIDTH`, 32, data word width; fixed at 32 for lane logic.
- `ADDR_WIDTH`, 10, memory word-address width; matches `mem`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 store, 0 load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result, valid with `resp_valid` for loads; 0 for stores/faults.
- `resp_fault`  out  1  misaligned or illegal size; valid with `resp_valid`.
- `mem_mode`  out  1  0 read, 1 write, to `mem`.
- `mem_addr`  out  ADDR_WIDTH  word address, `req_addr[ADDR_WIDTH+1:2]`.
- `mem_wdata`  out  32  write data to `mem`.
- `mem_rdata`  in  32  read data from `mem`; valid the cycle after a read cycle is presented.

## Operation
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE: `req_ready`=1; on `req_valid` latch addr, size, signed, write, wdata. Upper address bits above ADDR_WIDTH+1 ignored (wrap).
- Fault check at accept: half with addr[0]=1, word with addr[1:0]≠0, or size 11 -> RESP with `resp_fault`=1; no memory cycle issued.
- Word store -> WR (`mem_wdata`=wdata) -> RESP.
- Load or sub-word store -> RD (`mem_mode`=0, `mem_addr` driven) -> RD_WAIT (capture `mem_rdata`).
- RD_WAIT, load: extract lane (byte lane = addr[1:0], half lane = addr[1]), extend per `req_signed`, register into `resp_rdata`; -> RESP.
- RD_WAIT, sub-word store: merge wdata[7:0] or [15:0] into the selected lane of the read word, all other bytes preserved; -> WR with merged word.
- WR: `mem_mode`=1 for exactly one cycle.
- RESP: `resp_valid`=1 for one cycle; -> IDLE. No response backpressure.
- `mem_mode`=0 in every state except WR; `mem_addr` holds the latched word address from accept until next accept.

## Timing
- Accept at edge T (IDLE, valid). Response pulse cycle: fault T+1; word store T+2; load T+3; sub-word store T+4.
- Back-to-back: next accept possible in the cycle after RESP (IDLE); throughput one request per latency+1 cycles.
- `req_*` sampled only at accept; changes afterwards have no effect.
- Reset (async): state IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `mem_mode`=0, `mem_addr`=0, `mem_wdata`=0, `req_ready`=1 after release.
- Reset mid-sequence: operation abandoned, no response; a pending RMW write is never issued (`mem_mode` forced 0 immediately).
- `resp_rdata`/`resp_fault` hold until the next response, cleared to 0 on store or fault completion as specified.

## Test plan
- Word store 0xDEADBEEF to 0x40, then word load 0x40 -> store resp at T+2, load resp at T+3 with `resp_rdata`=0xDEADBEEF, fault 0.
- After above, byte store 0x11 to 0x41, word load 0x40 -> 0xDEAD11EF; exactly one `mem_mode`=1 cycle for the byte store.
- Word 0x80F0_7F81 at 0x50: signed byte load 0x50 -> 0xFFFFFF81; unsigned -> 0x00000081; signed half load 0x52 -> 0xFFFF80F0; unsigned half 0x52 -> 0x000080F0.
- Half load 0x43, word store 0x42, size 11 at 0x40 -> each `resp_fault`=1 at T+1, `resp_rdata`=0, `mem_mode` never 1.
- Half store 0xABCD to 0x46 with async reset asserted in RD_WAIT -> no `resp_valid`, no write cycle, all outputs 0, `req_ready`=1 after release.
- Request held valid continuously for 4 loads -> accepts only in IDLE, 4 responses in order, `req_ready` low while busy.
